// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants and reference sum for the carry-select adder
package csa_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int BLK_DEF   = 4;
   localparam int REF_W     = 32;

   // Plain wide addition, used as the golden value by the bench.
   function automatic logic [REF_W:0] ref_sum(input logic [REF_W-1:0] a,
                                              input logic [REF_W-1:0] b,
                                              input logic             cin);
      return {1'b0, a} + {1'b0, b} + {{REF_W{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/csa_rca_block.sv
// rtl/csa_rca_block.sv - BLK-bit ripple-carry adder built from full-adder equations
module csa_rca_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           ci,
   output logic [BLK-1:0] s,
   output logic           co
);

   logic carry;

   always_comb begin
      s     = '0;
      carry = ci;
      for (int i = 0; i < BLK; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - carry-select adder with registered {cout,y}
module carry_select_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLK   = BLK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] y,
   output logic             cout
);

   localparam int N = WIDTH / BLK;

   logic [WIDTH-1:0] sum;
   logic             sum_co;

   for (genvar k = 0; k < N; k++) begin : g_blk
      logic           ci_blk;
      logic           co_blk;
      logic [BLK-1:0] s_blk;

      if (k == 0) begin : g_lo
         assign ci_blk = cin;
         csa_rca_block #(.BLK(BLK)) u_rca (
            .a  (a[BLK-1:0]),
            .b  (b[BLK-1:0]),
            .ci (ci_blk),
            .s  (s_blk),
            .co (co_blk)
         );
      end else begin : g_hi
         logic [BLK-1:0] s0;
         logic [BLK-1:0] s1;
         logic           c0;
         logic           c1;

         assign ci_blk = g_blk[k-1].co_blk;

         csa_rca_block #(.BLK(BLK)) u_rca0 (
            .a  (a[k*BLK +: BLK]),
            .b  (b[k*BLK +: BLK]),
            .ci (1'b0),
            .s  (s0),
            .co (c0)
         );

         csa_rca_block #(.BLK(BLK)) u_rca1 (
            .a  (a[k*BLK +: BLK]),
            .b  (b[k*BLK +: BLK]),
            .ci (1'b1),
            .s  (s1),
            .co (c1)
         );

         // Both candidates are ready early; only this mux sits on the carry chain.
         assign s_blk  = ci_blk ? s1 : s0;
         assign co_blk = ci_blk ? c1 : c0;
      end

      assign sum[k*BLK +: BLK] = s_blk;
   end

   assign sum_co = g_blk[N-1].co_blk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y    <= '0;
         cout <= 1'b0;
      end else begin
         y    <= sum;
         cout <= sum_co;
      end
   end

endmodule

// File: tb/tb_carry_select_adder.sv
// tb/tb_carry_select_adder.sv - directed and swept checks of carry_select_adder
module tb_carry_select_adder;
   import csa_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        cin8;
   logic [7:0]  y8;
   logic        cout8;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        cin16;
   logic [15:0] y16;
   logic        cout16;

   int n_checks;
   int n_errors;

   carry_select_adder #(.WIDTH(8), .BLK(4)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .y     (y8),
      .cout  (cout8)
   );

   carry_select_adder #(.WIDTH(16), .BLK(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a16),
      .b     (b16),
      .cin   (cin16),
      .y     (y16),
      .cout  (cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apply8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [8:0] exp);
      a8   = av;
      b8   = bv;
      cin8 = cv;
      @(posedge clk);
      #1;
      check(tag, {23'd0, cout8, y8}, {23'd0, exp});
   endtask

   task automatic apply16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [16:0] exp);
      a16   = av;
      b16   = bv;
      cin16 = cv;
      @(posedge clk);
      #1;
      check(tag, {15'd0, cout16, y16}, {15'd0, exp});
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [8:0] e;
   } vec8_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [16:0] e;
   } vec16_t;

   vec8_t  v8[8];
   vec16_t v16[4];

   initial begin
      logic [32:0] r;
      int cyc;

      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0;

      v8[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
      v8[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
      v8[2] = '{8'h80, 8'h80, 1'b0, 9'h100};
      v8[3] = '{8'h00, 8'h00, 1'b1, 9'h001};
      v8[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
      v8[5] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
      v8[6] = '{8'h55, 8'hAA, 1'b1, 9'h100};
      v8[7] = '{8'h37, 8'h48, 1'b0, 9'h07F};

      v16[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
      v16[1] = '{16'h1234, 16'h5678, 1'b1, 17'h068AD};
      v16[2] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
      v16[3] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};

      // Reset held with all-ones inputs while the clock runs.
      #1 rst_n = 1'b0;
      #1 check("reset_async", {23'd0, cout8, y8}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", {23'd0, cout8, y8}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", {23'd0, cout8, y8}, 32'h1FF);

      foreach (v8[i]) apply8($sformatf("vec8_%0d", i), v8[i].a, v8[i].b, v8[i].c, v8[i].e);
      foreach (v16[i]) apply16($sformatf("vec16_%0d", i), v16[i].a, v16[i].b, v16[i].c, v16[i].e);

      for (int i = 0; i < 50; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rc;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         r  = ref_sum({16'd0, ra}, {16'd0, rb}, rc);
         apply16("rand16", ra, rb, rc, r[16:0]);
      end

      // Sweep: a fastest, cin toggling each cycle, b stepped across its full range.
      cyc = 0;
      for (int bi = 0; bi < 256; bi += 3) begin
         for (int ai = 0; ai < 256; ai++) begin
            r = ref_sum(32'(ai), 32'(bi), cyc[0]);
            apply8("sweep", 8'(ai), 8'(bi), cyc[0], r[8:0]);
            if (cyc == 5000) begin
               #2 rst_n = 1'b0;
               #1 check("reset_mid", {23'd0, cout8, y8}, 32'h0);
               rst_n = 1'b1;
            end
            cyc++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
